// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss fill controller: state encoding and
// block geometry.
package cache_fill_fsm_pkg;

  localparam int BLOCK_OFFSET_BITS = 4;
  localparam int WORDS_PER_BLOCK   = 8;
  localparam int CNT_WIDTH         = $clog2(WORDS_PER_BLOCK);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_counter.sv
// Word index counter for one side of a block fill; tc flags the last word.
module fill_word_counter
  import cache_fill_fsm_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign tc = &cnt;

endmodule

// File: rtl/dff.sv
// Generic D flip-flop bank with synchronous active-low reset to RESET_VAL.
module dff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= RESET_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss fill controller: fetches a 16-byte block word by word from main memory,
// streams it into the data array and writes the tag once the last word lands.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic [DATA_WIDTH-1:0] memory_data,
  input  logic                  memory_data_valid,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic                  write_data_array,
  output logic [ADDR_WIDTH-1:0] data_array_addr,
  output logic [DATA_WIDTH-1:0] data_array_wdata,
  output logic                  write_tag_array,
  output fill_state_t           fsm_state
);

  // Handshake: memory takes one request per cycle with no backpressure
  // (mem_read_en qualifies memory_address), and returns words strictly in
  // request order, each qualified by memory_data_valid for exactly one cycle.

  logic                  state_bit;
  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  issue_done_q;
  logic                  cnt_clr, issue_en, recv_en;
  logic [CNT_WIDTH-1:0]  issue_cnt, recv_cnt;
  logic                  issue_tc, recv_tc;

  dff #(.WIDTH(1), .RESET_VAL(1'b0)) u_state (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (state_d),
    .q     (state_bit)
  );
  assign state_q   = fill_state_t'(state_bit);
  assign fsm_state = state_q;

  fill_word_counter #(.WIDTH(CNT_WIDTH)) u_issue_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (issue_en),
    .cnt   (issue_cnt),
    .tc    (issue_tc)
  );

  fill_word_counter #(.WIDTH(CNT_WIDTH)) u_recv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (recv_en),
    .cnt   (recv_cnt),
    .tc    (recv_tc)
  );

  // The issue counter wraps after the last request, so a sticky flag stops issuing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q       <= '0;
      issue_done_q <= 1'b0;
    end else begin
      if (state_q == IDLE && miss_detected)
        base_q <= {miss_address[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], {BLOCK_OFFSET_BITS{1'b0}}};
      if (cnt_clr)
        issue_done_q <= 1'b0;
      else if (issue_en && issue_tc)
        issue_done_q <= 1'b1;
    end
  end

  always_comb begin
    state_d          = state_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    data_array_addr  = '0;
    data_array_wdata = '0;
    write_tag_array  = 1'b0;
    cnt_clr          = 1'b0;
    issue_en         = 1'b0;
    recv_en          = 1'b0;
    case (state_q)
      IDLE: begin
        fsm_busy = miss_detected;
        if (miss_detected) begin
          cnt_clr = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done_q) begin
          mem_read_en    = 1'b1;
          issue_en       = 1'b1;
          memory_address = {base_q[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], issue_cnt, 1'b0};
        end
        // Offsets replace the low bits of the base, so a block never carries out.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          recv_en          = 1'b1;
          data_array_addr  = {base_q[ADDR_WIDTH-1:BLOCK_OFFSET_BITS], recv_cnt, 1'b0};
          data_array_wdata = memory_data;
          if (recv_tc) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a queue-based fill model and an
// in-order main memory model with configurable latency and gaps.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic [15:0] memory_data;
  logic        memory_data_valid;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, data_array_addr, data_array_wdata;
  fill_state_t fsm_state;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .data_array_addr   (data_array_addr),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array),
    .fsm_state         (fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // fill model: a fill owes 8 requests and 8 writes, in block order
  bit          in_fill = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_wr_q[$];

  // memory model
  logic [15:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          mem_lat = 4;
  int          mem_gap = 0;
  int          next_ok = 0;

  // observation logs
  int          busy_cnt, busy_low_cnt, idle_busy_cnt, tag_count, tag_cyc, first_wr_cyc, miss_cyc;
  logic [15:0] req_log[$];
  logic [15:0] wr_log[$];
  logic        last_busy, last_rd, last_wr, last_tag;

  function automatic logic [15:0] mem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    busy_cnt = 0; busy_low_cnt = 0; idle_busy_cnt = 0; tag_count = 0;
    tag_cyc = -1; first_wr_cyc = -1;
    req_log.delete(); wr_log.delete();
  endtask

  // One cycle: check outputs at negedge, then advance inputs just after posedge.
  task automatic step();
    logic        e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_raddr, e_waddr, e_wdata;
    @(negedge clk);
    e_busy = 0; e_rd = 0; e_wr = 0; e_tag = 0;
    e_raddr = '0; e_waddr = '0; e_wdata = '0;
    if (!in_fill) begin
      e_busy = miss_detected;
    end else begin
      e_busy = 1;
      if (exp_q.size() > 0) begin
        e_rd = 1; e_raddr = exp_q.pop_front();
      end
      if (memory_data_valid && exp_wr_q.size() > 0) begin
        e_wr = 1; e_waddr = exp_wr_q.pop_front(); e_wdata = mem_fn(e_waddr);
        e_tag = (exp_wr_q.size() == 0);
      end
    end
    chk("fsm_busy", fsm_busy, e_busy);
    chk("mem_read_en", mem_read_en, e_rd);
    chk("memory_address", memory_address, e_raddr);
    chk("write_data_array", write_data_array, e_wr);
    chk("data_array_addr", data_array_addr, e_waddr);
    chk("data_array_wdata", data_array_wdata, e_wdata);
    chk("write_tag_array", write_tag_array, e_tag);
    chk("fsm_state", fsm_state, in_fill ? FILL : IDLE);

    last_busy = fsm_busy; last_rd = mem_read_en; last_wr = write_data_array; last_tag = write_tag_array;
    if (fsm_busy === 1'b1) busy_cnt++;
    if (fsm_busy === 1'b0) busy_low_cnt++;
    if (fsm_busy === 1'b1 && fsm_state == IDLE) idle_busy_cnt++;
    if (mem_read_en === 1'b1) req_log.push_back(memory_address);
    if (write_data_array === 1'b1) begin
      if (wr_log.size() == 0) first_wr_cyc = cyc;
      wr_log.push_back(data_array_addr);
    end
    if (write_tag_array === 1'b1) begin tag_count++; tag_cyc = cyc; end

    if (in_fill && e_tag) in_fill = 0;
    else if (!in_fill && miss_detected) begin
      in_fill = 1;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
        exp_q.push_back({miss_address[15:4], 4'h0} + 16'(2 * i));
        exp_wr_q.push_back({miss_address[15:4], 4'h0} + 16'(2 * i));
      end
    end
    if (!rst_n) begin in_fill = 0; exp_q.delete(); exp_wr_q.delete(); end

    if (mem_read_en === 1'b1) begin
      mem_addr_q.push_back(memory_address); mem_due_q.push_back(cyc + mem_lat);
    end
    @(posedge clk); #1;
    cyc++;
    if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc && cyc >= next_ok) begin
      memory_data_valid = 1;
      memory_data = mem_fn(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
      next_ok = cyc + 1 + mem_gap;
    end else begin
      memory_data_valid = 0;
      memory_data = 16'($urandom_range(0, 65535));
    end
  endtask

  // Present a one-cycle miss, optionally re-pulse a miss at 0x4000 mid-fill,
  // run until the model says the fill is over, then one idle cycle.
  task automatic run_fill(input logic [15:0] a, input int glitch);
    clear_logs();
    miss_cyc = cyc; miss_detected = 1; miss_address = a;
    step();
    miss_detected = 0;
    for (int i = 1; i < 80 && in_fill; i++) begin
      if (i == glitch) begin miss_detected = 1; miss_address = 16'h4000; end
      step();
      miss_detected = 0;
    end
    chk("fill_finished", 16'(in_fill), 16'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; miss_detected = 0; miss_address = 16'h0;
    memory_data = 16'h0; memory_data_valid = 0;
    clear_logs();

    // reset
    step(); step();
    chk("reset_state", fsm_state, IDLE);
    chk("reset_busy", 16'(last_busy), 16'd0);
    rst_n = 1;
    step();

    // single miss at 0x1236, 4-cycle memory
    run_fill(16'h1236, -1);
    chk("fill1_busy_cycles", busy_cnt, 13);
    chk("fill1_req_count", req_log.size(), 8);
    chk("fill1_req_first", req_log[0], 16'h1230);
    chk("fill1_req_last", req_log[7], 16'h123E);
    chk("fill1_wr_last", wr_log[7], 16'h123E);
    chk("fill1_first_wr_cycle", first_wr_cyc - miss_cyc, 5);
    chk("fill1_tag_count", tag_count, 1);
    chk("fill1_tag_cycle", tag_cyc - miss_cyc, 12);

    // top-of-memory block
    run_fill(16'hFFFF, -1);
    chk("top_req_first", req_log[0], 16'hFFF0);
    chk("top_req_last", req_log[7], 16'hFFFE);
    chk("top_wr_last", wr_log[7], 16'hFFFE);

    // 2-cycle gaps between valids
    mem_gap = 2;
    run_fill(16'h3456, -1);
    mem_gap = 0;
    chk("gap_wr_count", wr_log.size(), 8);
    chk("gap_wr_first", wr_log[0], 16'h3450);
    chk("gap_tag_count", tag_count, 1);
    chk("gap_tag_cycle", tag_cyc - miss_cyc, 26);
    chk("gap_busy_cycles", busy_cnt, 27);

    // miss at 0x4000 during a 0x2000 fill is ignored
    run_fill(16'h2000, 3);
    chk("ign_wr_first", wr_log[0], 16'h2000);
    chk("ign_wr_last", wr_log[7], 16'h200E);
    chk("ign_tag_count", tag_count, 1);
    chk("ign_busy_cycles", busy_cnt, 13);

    // reset one cycle after the 3rd valid
    clear_logs();
    miss_detected = 1; miss_address = 16'h0500;
    step();
    miss_detected = 0;
    for (int i = 0; i < 30 && wr_log.size() < 3; i++) step();
    chk("abort_saw_3_writes", wr_log.size(), 3);
    rst_n = 0;
    step();
    rst_n = 1;
    step();
    chk("abort_busy", 16'(last_busy), 16'd0);
    chk("abort_rd", 16'(last_rd), 16'd0);
    chk("abort_wr", 16'(last_wr), 16'd0);
    for (int i = 0; i < 30 && mem_addr_q.size() > 0; i++) step();
    chk("abort_mem_drained", mem_addr_q.size(), 0);
    step();
    chk("abort_tag_count", tag_count, 0);
    chk("abort_wr_count_le_4", 16'(wr_log.size() <= 4), 16'd1);
    run_fill(16'h0040, -1);
    chk("post_abort_wr_first", wr_log[0], 16'h0040);
    chk("post_abort_wr_last", wr_log[7], 16'h004E);
    chk("post_abort_tag_count", tag_count, 1);

    // miss held high across two consecutive fills
    clear_logs();
    miss_cyc = cyc;
    miss_detected = 1; miss_address = 16'h0100;
    for (int i = 0; i < 40 && tag_count < 1; i++) step();
    miss_address = 16'h0200;
    for (int i = 0; i < 40 && tag_count < 2; i++) step();
    miss_detected = 0;
    chk("b2b_busy_never_low", busy_low_cnt, 0);
    chk("b2b_tag_count", tag_count, 2);
    chk("b2b_idle_busy_cycles", idle_busy_cnt, 2);
    chk("b2b_busy_cycles", busy_cnt, 26);
    chk("b2b_req_second", req_log[8], 16'h0200);
    chk("b2b_wr_second_last", wr_log[15], 16'h020E);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
